// File: rtl/pc_gen_pkg.sv
// ============================================================================
// pc_gen_pkg : shared constants and FSM state type for the IF-stage PC unit
// Rev 1.0
// ============================================================================
`default_nettype none

package pc_gen_pkg;

    localparam logic [2:0]  HOLD_NONE        = 3'd0;
    localparam logic [2:0]  HOLD_PC          = 3'd1;
    localparam logic [2:0]  HOLD_IF          = 3'd2;
    localparam logic [2:0]  HOLD_ID          = 3'd3;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INS_NOP          = 32'h0000_0013;

    typedef enum logic [0:0] {
        PC_BOOT = 1'b0,
        PC_RUN  = 1'b1
    } pc_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_gen_if.sv
// ============================================================================
// pc_gen_if : control inputs and fetch outputs of the PC generator
// Rev 1.0
// ============================================================================
`default_nettype none

interface pc_gen_if;

    logic [2:0]  hold_flag_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        int_assert_i;
    logic [31:0] int_addr_i;
    logic        rom_ready_i;
    logic [31:0] pc_o;
    logic        req_o;
    logic        boot_done_o;
    logic        misalign_o;

    // The PC generator is the fetch master; ctrl/EX/clint/ROM form the slave side.
    modport master (
        input  hold_flag_i, jump_flag_i, jump_addr_i,
        input  int_assert_i, int_addr_i, rom_ready_i,
        output pc_o, req_o, boot_done_o, misalign_o
    );

    modport slave (
        output hold_flag_i, jump_flag_i, jump_addr_i,
        output int_assert_i, int_addr_i, rom_ready_i,
        input  pc_o, req_o, boot_done_o, misalign_o
    );

endinterface

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// pc_gen : program counter and fetch sequencer (boot delay, redirect, hold)
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          BOOT_CYCLES = 4
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    pc_gen_if.master   bus
);

    localparam bit         NO_BOOT   = (BOOT_CYCLES == 0);
    localparam logic [7:0] BOOT_LAST = NO_BOOT ? 8'd0 : 8'(BOOT_CYCLES - 1);

    pc_state_e   state;
    logic [7:0]  cnt;
    logic [31:0] pc;
    logic        req;
    logic        boot_done;
    logic        misalign;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] next_pc;

    // Interrupt outranks jump; redirects bypass hold and back-pressure.
    always_comb begin
        redirect = 1'b0;
        target   = 32'h0;
        if (bus.int_assert_i) begin
            redirect = 1'b1;
            target   = bus.int_addr_i;
        end else if (bus.jump_flag_i) begin
            redirect = 1'b1;
            target   = bus.jump_addr_i;
        end

        if (redirect) begin
            next_pc = {target[31:2], 2'b00};
        end else if ((bus.hold_flag_i != HOLD_NONE) || !bus.rom_ready_i) begin
            next_pc = pc;
        end else begin
            next_pc = pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PC_BOOT;
            cnt       <= 8'd0;
            pc        <= RESET_PC;
            req       <= 1'b0;
            boot_done <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            case (state)
                PC_BOOT: begin
                    pc       <= RESET_PC;
                    misalign <= 1'b0;
                    cnt      <= cnt + 8'd1;
                    if (NO_BOOT || (cnt == BOOT_LAST)) begin
                        state     <= PC_RUN;
                        req       <= 1'b1;
                        boot_done <= 1'b1;
                    end else begin
                        req       <= 1'b0;
                        boot_done <= 1'b0;
                    end
                end
                PC_RUN: begin
                    pc        <= next_pc;
                    req       <= 1'b1;
                    boot_done <= 1'b1;
                    misalign  <= redirect && (target[1:0] != 2'b00);
                end
                default: begin
                    state     <= PC_BOOT;
                    cnt       <= 8'd0;
                    pc        <= RESET_PC;
                    req       <= 1'b0;
                    boot_done <= 1'b0;
                    misalign  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_o        = pc;
    assign bus.req_o       = req;
    assign bus.boot_done_o = boot_done;
    assign bus.misalign_o  = misalign;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// tb_pc_gen : directed self-checking bench for pc_gen
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_gen;
    import pc_gen_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pc_gen_if bus ();

    pc_gen #(
        .RESET_PC    (32'h0000_0100),
        .BOOT_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] hold, input logic jmp, input logic [31:0] jaddr,
                         input logic intr, input logic [31:0] iaddr, input logic rdy);
        bus.hold_flag_i  = hold;
        bus.jump_flag_i  = jmp;
        bus.jump_addr_i  = jaddr;
        bus.int_assert_i = intr;
        bus.int_addr_i   = iaddr;
        bus.rom_ready_i  = rdy;
    endtask

    task automatic idle();
        drive(HOLD_NONE, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle();
        step();
        step();
        check("rst_pc",   bus.pc_o,        32'h100);
        check("rst_req",  {31'd0, bus.req_o},       32'd0);
        check("rst_boot", {31'd0, bus.boot_done_o}, 32'd0);
        check("rst_mis",  {31'd0, bus.misalign_o},  32'd0);

        // Boot delay with a jump request that must be discarded.
        drive(HOLD_NONE, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("boot_req_%0d", i), {31'd0, bus.req_o}, 32'd0);
            check($sformatf("boot_pc_%0d", i),  bus.pc_o, 32'h100);
        end
        step();
        check("first_req",  {31'd0, bus.req_o},       32'd1);
        check("first_boot", {31'd0, bus.boot_done_o}, 32'd1);
        check("first_pc",   bus.pc_o,                 32'h100);
        idle();
        step();
        check("seq_104", bus.pc_o, 32'h104);
        step();
        check("seq_108", bus.pc_o, 32'h108);

        // Hold code 1 for three cycles at 0x20.
        drive(HOLD_NONE, 1'b1, 32'h20, 1'b0, 32'h0, 1'b1);
        step();
        check("jmp_20", bus.pc_o, 32'h20);
        drive(HOLD_PC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_%0d", i), bus.pc_o, 32'h20);
            check($sformatf("hold_req_%0d", i), {31'd0, bus.req_o}, 32'd1);
        end
        idle();
        step();
        check("hold_resume", bus.pc_o, 32'h24);

        // Same with ROM back-pressure.
        drive(HOLD_NONE, 1'b1, 32'h20, 1'b0, 32'h0, 1'b1);
        step();
        check("jmp_20b", bus.pc_o, 32'h20);
        drive(HOLD_NONE, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_%0d", i), bus.pc_o, 32'h20);
        end
        idle();
        step();
        check("stall_resume", bus.pc_o, 32'h24);

        // Jump under hold, aligned then misaligned target.
        drive(HOLD_IF, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1);
        step();
        check("jhold_pc",  bus.pc_o, 32'h400);
        check("jhold_mis", {31'd0, bus.misalign_o}, 32'd0);
        drive(HOLD_IF, 1'b1, 32'h402, 1'b0, 32'h0, 1'b1);
        step();
        check("jmis_pc",  bus.pc_o, 32'h400);
        check("jmis_mis", {31'd0, bus.misalign_o}, 32'd1);
        idle();
        step();
        check("jmis_pc2",  bus.pc_o, 32'h404);
        check("jmis_drop", {31'd0, bus.misalign_o}, 32'd0);

        // Interrupt beats a simultaneous jump.
        drive(HOLD_NONE, 1'b1, 32'h400, 1'b1, 32'h80, 1'b1);
        step();
        check("int_win", bus.pc_o, 32'h80);
        check("int_mis", {31'd0, bus.misalign_o}, 32'd0);
        drive(HOLD_NONE, 1'b1, 32'h400, 1'b1, 32'h83, 1'b1);
        step();
        check("int_mis_pc",  bus.pc_o, 32'h80);
        check("int_mis_flg", {31'd0, bus.misalign_o}, 32'd1);

        // Redirect while the ROM is stalled still loads the target.
        drive(HOLD_NONE, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        step();
        check("rdr_stall", bus.pc_o, 32'h200);
        drive(HOLD_NONE, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        check("rdr_stall2", bus.pc_o, 32'h200);

        // Wrap-around from the top of the address space.
        drive(HOLD_NONE, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
        step();
        check("wrap_top", bus.pc_o, 32'hFFFF_FFFC);
        idle();
        step();
        check("wrap_zero", bus.pc_o, 32'h0);
        check("wrap_mis",  {31'd0, bus.misalign_o}, 32'd0);
        step();
        check("wrap_four", bus.pc_o, 32'h4);

        // Asynchronous reset mid-run, then the boot delay repeats.
        drive(HOLD_NONE, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        step();
        check("pre_rst_pc", bus.pc_o, 32'h40);
        idle();
        rst_n = 1'b0;
        #1;
        check("mid_rst_pc",   bus.pc_o,                 32'h100);
        check("mid_rst_req",  {31'd0, bus.req_o},       32'd0);
        check("mid_rst_boot", {31'd0, bus.boot_done_o}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("reboot_req_%0d", i), {31'd0, bus.req_o}, 32'd0);
        end
        step();
        check("reboot_req", {31'd0, bus.req_o}, 32'd1);
        check("reboot_pc",  bus.pc_o,           32'h100);
        step();
        check("reboot_seq", bus.pc_o, 32'h104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
